// File: rtl/gpio_pkg.sv
// Shared types and default constants for the GPIO command-FIFO port.
package gpio_pkg;

    // Default build-time configuration
    localparam int GPIO_WIDTH_DEF  = 8;
    localparam int GPIO_DEPTH_DEF  = 16;
    localparam int GPIO_HOLD_W_DEF = 8;

    // Pop sequencer states: IDLE waits for work, HOLD keeps an entry on the pins
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } pop_state_t;

    // Width of an occupancy counter that must be able to represent "depth" itself
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/gpio_sync_fifo.sv
// Single-clock FIFO with registered pointers and a combinational head view.
// Push while full and pop while empty are ignored, so callers may hold the
// request lines without pre-qualifying them.
module gpio_sync_fifo
    import gpio_pkg::*;
#(
    parameter int WIDTH = 2 * GPIO_WIDTH_DEF,
    parameter int DEPTH = GPIO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array write port
    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers and count, so stale contents are never observable and the
    // array can map onto plain RAM without a reset network.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    // NOTE: every register in an always_ff uses <= so all flops sample the
    // pre-edge values; a blocking = here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));

endmodule

// File: rtl/gpio_fifo_port.sv
// GPIO port driven from a command FIFO. Each queued entry carries a pin
// direction mask and output levels; the pop sequencer applies one entry at a
// time and holds it on the pins for hold+1 cycles. Input pins are brought in
// through a two-flop synchronizer and merged with driven pins in pin_status.
//
// Optional feature: define GPIO_EDGE_IRQ_EN to build per-pin rising-edge
// interrupts on input pins. Without it irq_status and irq are tied to zero.
module gpio_fifo_port
    import gpio_pkg::*;
#(
    parameter int WIDTH  = GPIO_WIDTH_DEF,
    parameter int DEPTH  = GPIO_DEPTH_DEF,
    parameter int HOLD_W = GPIO_HOLD_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    // command push side
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [WIDTH-1:0]         wr_dir,
    input  logic [HOLD_W-1:0]        hold,
    // pins
    input  logic [WIDTH-1:0]         gpio_in,
    output logic [WIDTH-1:0]         gpio_out,
    output logic [WIDTH-1:0]         gpio_oe,
    output logic [WIDTH-1:0]         pin_status,
    // status
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     busy,
    // edge interrupts
    input  logic [WIDTH-1:0]         edge_mask,
    input  logic [WIDTH-1:0]         irq_clr,
    output logic [WIDTH-1:0]         irq_status,
    output logic                     irq
);

    localparam int EW = 2 * WIDTH;

    pop_state_t        state;
    pop_state_t        state_nxt;
    logic [EW-1:0]     head;
    logic              fifo_pop;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;
    logic [WIDTH-1:0]  sync_1;
    logic [WIDTH-1:0]  sync_in;

    // Command storage: each entry is {direction mask, output levels}
    gpio_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_valid),
        .push_data ({wr_dir, wr_data}),
        .pop       (fifo_pop),
        .pop_data  (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    assign wr_ready  = !full;
    assign hold_done = (hold_cnt == '0);

    // Pop sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pop sequencer next-state logic
    // NOTE: state_nxt is given a default before the case so every path
    // assigns it; a missing branch would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (hold_done && empty) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pop sequencer outputs: pop request and busy flag
    always_comb begin
        fifo_pop = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                fifo_pop = !empty;
            end
            HOLD: begin
                busy     = 1'b1;
                fifo_pop = hold_done && !empty;
            end
            default: begin
                fifo_pop = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // Pin registers load on pop and persist in IDLE; hold is sampled only at pop
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out <= '0;
            gpio_oe  <= '0;
            hold_cnt <= '0;
        end else if (fifo_pop) begin
            {gpio_oe, gpio_out} <= head;
            hold_cnt            <= hold;
        end else if (state == HOLD && !hold_done) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous pin inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1  <= '0;
            sync_in <= '0;
        end else begin
            sync_1  <= gpio_in;
            sync_in <= sync_1;
        end
    end

    // Driven pins report their own level, input pins report the synchronized level
    assign pin_status = (gpio_oe & gpio_out) | (~gpio_oe & sync_in);

`ifdef GPIO_EDGE_IRQ_EN
    logic [WIDTH-1:0] sync_prev;
    logic [WIDTH-1:0] rise;

    // A qualifying edge is a 0->1 transition on an enabled input-direction pin
    assign rise = sync_in & ~sync_prev & ~gpio_oe & edge_mask;

    // Sticky interrupt flags; a new edge wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_prev  <= '0;
            irq_status <= '0;
        end else begin
            sync_prev  <= sync_in;
            irq_status <= (irq_status & ~irq_clr) | rise;
        end
    end

    assign irq = |irq_status;
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{edge_mask, irq_clr};
    assign irq_status        = '0;
    assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_fifo_port.sv
// Directed bench for gpio_fifo_port: reset, push-to-pin latency, hold timing,
// full FIFO back-pressure and in-order drain, mixed direction pin view,
// edge interrupts (expected zero when built without GPIO_EDGE_IRQ_EN) and
// reset in the middle of a hold.
module tb_gpio_fifo_port;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int HOLD_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  wr_dir;
    logic [HOLD_W-1:0] hold;
    logic [WIDTH-1:0]  gpio_in;
    logic [WIDTH-1:0]  gpio_out;
    logic [WIDTH-1:0]  gpio_oe;
    logic [WIDTH-1:0]  pin_status;
    logic [4:0]        count;
    logic              empty;
    logic              full;
    logic              busy;
    logic [WIDTH-1:0]  edge_mask;
    logic [WIDTH-1:0]  irq_clr;
    logic [WIDTH-1:0]  irq_status;
    logic              irq;

    int total = 0;
    int bad   = 0;

    gpio_fifo_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .HOLD_W (HOLD_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_dir     (wr_dir),
        .hold       (hold),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .gpio_oe    (gpio_oe),
        .pin_status (pin_status),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .busy       (busy),
        .edge_mask  (edge_mask),
        .irq_clr    (irq_clr),
        .irq_status (irq_status),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [WIDTH-1:0] dir, input logic [WIDTH-1:0] data);
        wr_valid = 1'b1;
        wr_dir   = dir;
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
    endtask

    logic [WIDTH-1:0] exp_irq;
    logic             exp_irq_any;
    int               n;

    initial begin
`ifdef GPIO_EDGE_IRQ_EN
        exp_irq     = 8'h01;
        exp_irq_any = 1'b1;
`else
        exp_irq     = 8'h00;
        exp_irq_any = 1'b0;
`endif
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_data   = '0;
        wr_dir    = '0;
        hold      = '0;
        gpio_in   = '0;
        edge_mask = '0;
        irq_clr   = '0;

        // ---------------- reset ----------------
        tick();
        tick();
        check("rst_oe",    gpio_oe,  8'h00);
        check("rst_out",   gpio_out, 8'h00);
        check("rst_empty", empty,    1'b1);
        check("rst_ready", wr_ready, 1'b1);
        check("rst_full",  full,     1'b0);
        check("rst_count", count,    5'd0);
        check("rst_busy",  busy,     1'b0);
        check("rst_irq",   irq,      1'b0);
        rst = 1'b0;
        tick();

        // ---------------- latency ----------------
        hold = 8'd0;
        push_one(8'hFF, 8'hA5);
        check("lat_out_e1", gpio_out, 8'h00);
        check("lat_cnt_e1", count,    5'd1);
        tick();
        check("lat_out",   gpio_out,   8'hA5);
        check("lat_oe",    gpio_oe,    8'hFF);
        check("lat_pin",   pin_status, 8'hA5);
        check("lat_busy",  busy,       1'b1);
        check("lat_empty", empty,      1'b1);
        tick();
        check("lat_idle",   busy,     1'b0);
        check("lat_retain", gpio_out, 8'hA5);

        // ---------------- hold timing ----------------
        hold = 8'd3;
        wr_valid = 1'b1;
        wr_dir   = 8'hFF;
        wr_data  = 8'h55;
        tick();
        check("hold_cnt_a", count,    5'd1);
        check("hold_out_a", gpio_out, 8'hA5);
        wr_data = 8'hAA;
        tick();
        wr_valid = 1'b0;
        check("hold_55_0",  gpio_out, 8'h55);
        check("hold_cnt_b", count,    5'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("hold_55_%0d", i), gpio_out, 8'h55);
        end
        tick();
        check("hold_aa_0",  gpio_out, 8'hAA);
        check("hold_cnt_f", count,    5'd0);
        check("hold_busy",  busy,     1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check($sformatf("hold_aa_%0d", i), gpio_out, 8'hAA);
            check($sformatf("hold_busy_%0d", i), busy, 1'b1);
        end
        tick();
        check("hold_idle_busy", busy,     1'b0);
        check("hold_idle_out",  gpio_out, 8'hAA);
        tick();
        check("hold_idle_keep", gpio_out, 8'hAA);

        // ---------------- full / back-pressure ----------------
        hold = 8'hFF;
        for (int k = 1; k <= 18; k++) begin
            wr_valid = 1'b1;
            wr_dir   = 8'hFF;
            wr_data  = 8'(8'h10 + k);
            check($sformatf("full_rdy_%0d", k), wr_ready, (k <= 17) ? 1'b1 : 1'b0);
            tick();
        end
        wr_valid = 1'b0;
        check("full_count", count,    5'd16);
        check("full_flag",  full,     1'b1);
        check("full_ready", wr_ready, 1'b0);
        check("full_head",  gpio_out, 8'h11);
        // Shorter hold applies only from the next pop; d1 keeps its 256 cycles
        hold = 8'd0;
        n = 0;
        while (gpio_out == 8'h11 && n < 400) begin
            tick();
            n++;
        end
        check("full_d1_hold", n, 240);
        check("drain_d2", gpio_out, 8'h12);
        for (int k = 3; k <= 17; k++) begin
            tick();
            check($sformatf("drain_d%0d", k), gpio_out, 8'(8'h10 + k));
        end
        tick();
        check("drain_empty", empty,    1'b1);
        check("drain_busy",  busy,     1'b0);
        check("drain_last",  gpio_out, 8'h21);

        // ---------------- mixed direction ----------------
        gpio_in = 8'h0F;
        push_one(8'hF0, 8'hF0);
        tick();
        check("mix_oe",  gpio_oe,    8'hF0);
        check("mix_pin", pin_status, 8'hFF);
        gpio_in = 8'h5F;
        tick();
        tick();
        check("mix_hi_ignored", pin_status, 8'hFF);
        gpio_in = 8'h00;
        tick();
        check("mix_sync_lag", pin_status, 8'hFF);
        tick();
        check("mix_lo_follow", pin_status, 8'hF0);

        // ---------------- edge interrupts ----------------
        push_one(8'h00, 8'h00);
        tick();
        tick();
        check("irq_oe_in", gpio_oe,    8'h00);
        edge_mask = 8'h01;
        check("irq_quiet", irq_status, 8'h00);
        gpio_in = 8'h01;
        tick();
        tick();
        check("irq_e2", irq_status, 8'h00);
        tick();
        check("irq_set",     irq_status, exp_irq);
        check("irq_set_any", irq,        exp_irq_any);
        gpio_in = 8'h00;
        irq_clr = 8'h01;
        tick();
        irq_clr = 8'h00;
        check("irq_clr", irq_status, 8'h00);
        check("irq_clr_any", irq, 1'b0);
        tick();
        tick();
        tick();
        gpio_in = 8'h03;
        tick();
        tick();
        irq_clr = 8'h01;
        tick();
        irq_clr = 8'h00;
        check("irq_set_wins", irq_status, exp_irq);

        // ---------------- reset during hold ----------------
        edge_mask = 8'h00;
        hold = 8'd10;
        wr_valid = 1'b1;
        wr_dir   = 8'hFF;
        wr_data  = 8'h3C;
        tick();
        wr_data = 8'hC3;
        tick();
        wr_valid = 1'b0;
        tick();
        check("mid_busy",  busy,     1'b1);
        check("mid_count", count,    5'd1);
        check("mid_out",   gpio_out, 8'h3C);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_empty", empty,    1'b1);
        check("mid_rst_count", count,    5'd0);
        check("mid_rst_oe",    gpio_oe,  8'h00);
        check("mid_rst_out",   gpio_out, 8'h00);
        check("mid_rst_busy",  busy,     1'b0);
        check("mid_rst_irq",   irq,      1'b0);
        tick();
        tick();
        check("mid_rst_nopop", gpio_oe, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
